// File: rtl/mss_apb_pkg.sv
// Shared definitions for the MSS APB responder: bus widths, register map,
// FSM state encoding, default ID value and the wait-state ceiling.
package mss_apb_pkg;

    localparam int unsigned ADDR_W          = 20;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned EVT_W           = 8;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned WAIT_STATES_MAX = 15;
    localparam int unsigned SCRATCH_N       = 5;

    localparam logic [DATA_W-1:0] ID_VALUE_DEFAULT = 32'h4D53_5301;

    // Word-aligned register offsets
    localparam logic [ADDR_W-1:0] OFF_ID       = 20'h0_0000;
    localparam logic [ADDR_W-1:0] OFF_CTRL     = 20'h0_0004;
    localparam logic [ADDR_W-1:0] OFF_STATUS   = 20'h0_0008;
    localparam logic [ADDR_W-1:0] OFF_SCRATCH0 = 20'h0_000C;
    localparam logic [ADDR_W-1:0] OFF_LAST     = 20'h0_001C;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } apb_state_e;

    // Misaligned or beyond the last register -> slave error
    function automatic logic addr_err(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (a > OFF_LAST);
    endfunction

endpackage

// File: rtl/mss_apb_evt_status.sv
// Event status register with write-1-to-clear and the masked level interrupt.
// Ports:
//   i_clk, i_rst     : fabric clock, synchronous active-high reset
//   i_event          : single-cycle event pulses, one per STATUS bit
//   i_clr_en         : committed write to STATUS this cycle
//   i_clr_mask       : write data bits to clear
//   i_ctrl           : interrupt enable mask
//   o_status         : current STATUS value
//   o_fabint         : registered OR of (STATUS & CTRL)
module mss_apb_evt_status
    import mss_apb_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [EVT_W-1:0] i_event,
    input  logic             i_clr_en,
    input  logic [EVT_W-1:0] i_clr_mask,
    input  logic [EVT_W-1:0] i_ctrl,
    output logic [EVT_W-1:0] o_status,
    output logic             o_fabint
);

    logic [EVT_W-1:0] r_status;
    logic             r_fabint;
    logic [EVT_W-1:0] w_clr;

    assign w_clr = i_clr_en ? i_clr_mask : '0;

    // Clear is applied first so a same-cycle event re-sets the bit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_status <= '0;
            r_fabint <= 1'b0;
        end else begin
            r_status <= (r_status & ~w_clr) | i_event;
            r_fabint <= |(r_status & i_ctrl);
        end
    end

    assign o_status = r_status;
    assign o_fabint = r_fabint;

endmodule

// File: rtl/mss_apb_responder.sv
// APB completer for the MSS fabric interface: programmable wait states,
// ID / CTRL / STATUS / SCRATCH register map, slave error on bad addresses
// and a level interrupt driven from event STATUS bits.
// Ports:
//   FCLK, RESET          : fabric clock, synchronous active-high reset
//   HMPSEL, HMPENABLE    : APB select and access-phase enable
//   HMPWRITE, HMADDR     : direction and byte address
//   HMWDATA / HMRDATA    : write / read data (read data is 0 outside ready)
//   HMPREADY, HMPSLVERR  : one-cycle completion and its error flag
//   EVENT_IN             : event pulses into STATUS
//   FABINT               : interrupt to the MSS
module mss_apb_responder
    import mss_apb_pkg::*;
#(
    parameter int unsigned       WAIT_STATES = 1,
    parameter logic [DATA_W-1:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
    input  logic              FCLK,
    input  logic              RESET,
    input  logic              HMPSEL,
    input  logic              HMPENABLE,
    input  logic              HMPWRITE,
    input  logic [ADDR_W-1:0] HMADDR,
    input  logic [DATA_W-1:0] HMWDATA,
    output logic [DATA_W-1:0] HMRDATA,
    output logic              HMPREADY,
    output logic              HMPSLVERR,
    input  logic [EVT_W-1:0]  EVENT_IN,
    output logic              FABINT
);

    localparam logic [CNT_W-1:0] LP_WAIT =
        CNT_W'((WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES);
    localparam int unsigned IDX_W = 3;

    apb_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic              r_ready;
    logic              r_slverr;
    logic [DATA_W-1:0] r_rdata;
    logic [EVT_W-1:0]  r_ctrl;
    logic [DATA_W-1:0] r_scratch [SCRATCH_N];

    logic [EVT_W-1:0]  w_status;
    logic              w_setup;
    logic              w_ready_go;
    logic [ADDR_W-1:0] w_src_addr;
    logic              w_src_write;
    logic              w_src_err;
    logic [IDX_W-1:0]  w_rd_idx;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_wr_en;
    logic              w_wr_ctrl;
    logic              w_wr_status;
    logic              w_wr_scr;

    // A setup phase is accepted from IDLE and, for back-to-back traffic, from DONE
    assign w_setup = HMPSEL && !HMPENABLE &&
                     ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Ready rises at the setup edge for zero wait states, else when the count runs out
    assign w_ready_go = (w_setup && (LP_WAIT == '0)) ||
                        ((r_state == ST_ACCESS) && !r_ready && HMPSEL &&
                         HMPENABLE && (r_cnt == CNT_W'(1)));

    // With zero wait states the transfer is decoded straight off the bus
    assign w_src_addr  = (r_state == ST_ACCESS) ? r_addr  : HMADDR;
    assign w_src_write = (r_state == ST_ACCESS) ? r_write : HMPWRITE;
    assign w_src_err   = addr_err(w_src_addr);

    assign w_rd_idx = IDX_W'((w_src_addr - OFF_SCRATCH0) >> 2);
    assign w_wr_idx = IDX_W'((r_addr - OFF_SCRATCH0) >> 2);

    // Read mux; error addresses are zeroed when the data is registered
    always_comb begin
        w_rd_data = '0;
        if (w_src_addr == OFF_ID) begin
            w_rd_data = ID_VALUE;
        end else if (w_src_addr == OFF_CTRL) begin
            w_rd_data = DATA_W'(r_ctrl);
        end else if (w_src_addr == OFF_STATUS) begin
            w_rd_data = DATA_W'(w_status);
        end else if (w_rd_idx < IDX_W'(SCRATCH_N)) begin
            w_rd_data = r_scratch[w_rd_idx];
        end
    end

    // Writes commit at the end of the ready cycle
    assign w_wr_en     = (r_state == ST_ACCESS) && r_ready && r_write && !addr_err(r_addr);
    assign w_wr_ctrl   = w_wr_en && (r_addr == OFF_CTRL);
    assign w_wr_status = w_wr_en && (r_addr == OFF_STATUS);
    assign w_wr_scr    = w_wr_en && (r_addr >= OFF_SCRATCH0);

    // APB transfer FSM with registered ready, error and read data
    always_ff @(posedge FCLK) begin
        if (RESET) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_wdata  <= '0;
            r_ready  <= 1'b0;
            r_slverr <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_ready  <= 1'b0;
            r_slverr <= 1'b0;
            r_rdata  <= '0;

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_setup) begin
                        r_state <= ST_ACCESS;
                        r_addr  <= HMADDR;
                        r_write <= HMPWRITE;
                        r_wdata <= HMWDATA;
                        r_cnt   <= LP_WAIT;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (r_ready) begin
                        r_state <= ST_DONE;
                    end else if (!HMPSEL) begin
                        r_state <= ST_IDLE;
                    end else if (HMPENABLE) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_ready_go) begin
                r_ready  <= 1'b1;
                r_slverr <= w_src_err;
                r_rdata  <= (w_src_write || w_src_err) ? '0 : w_rd_data;
            end
        end
    end

    // CTRL and SCRATCH storage
    always_ff @(posedge FCLK) begin
        if (RESET) begin
            r_ctrl <= '0;
            for (int unsigned i = 0; i < SCRATCH_N; i++) begin
                r_scratch[i] <= '0;
            end
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl <= r_wdata[EVT_W-1:0];
            end
            for (int unsigned i = 0; i < SCRATCH_N; i++) begin
                if (w_wr_scr && (w_wr_idx == IDX_W'(i))) begin
                    r_scratch[i] <= r_wdata;
                end
            end
        end
    end

    mss_apb_evt_status u_evt (
        .i_clk      (FCLK),
        .i_rst      (RESET),
        .i_event    (EVENT_IN),
        .i_clr_en   (w_wr_status),
        .i_clr_mask (r_wdata[EVT_W-1:0]),
        .i_ctrl     (r_ctrl),
        .o_status   (w_status),
        .o_fabint   (FABINT)
    );

    assign HMPREADY  = r_ready;
    assign HMPSLVERR = r_slverr;
    assign HMRDATA   = r_rdata;

endmodule

// File: tb/tb_mss_apb_responder.sv
// Bench for mss_apb_responder: one instance with WAIT_STATES=0 (index 0)
// and one with WAIT_STATES=1 (index 1), sharing clock and reset.
module tb_mss_apb_responder;

    localparam logic [31:0] ID = 32'h4D53_5301;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [19:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];
    logic [7:0]  evt     [2];
    logic        fabint  [2];

    always #5 clk = ~clk;

    mss_apb_responder #(.WAIT_STATES(0)) u_ws0 (
        .FCLK(clk), .RESET(rst), .HMPSEL(psel[0]), .HMPENABLE(penable[0]),
        .HMPWRITE(pwrite[0]), .HMADDR(paddr[0]), .HMWDATA(pwdata[0]),
        .HMRDATA(prdata[0]), .HMPREADY(pready[0]), .HMPSLVERR(pslverr[0]),
        .EVENT_IN(evt[0]), .FABINT(fabint[0])
    );

    mss_apb_responder #(.WAIT_STATES(1)) u_ws1 (
        .FCLK(clk), .RESET(rst), .HMPSEL(psel[1]), .HMPENABLE(penable[1]),
        .HMPWRITE(pwrite[1]), .HMADDR(paddr[1]), .HMWDATA(pwdata[1]),
        .HMRDATA(prdata[1]), .HMPREADY(pready[1]), .HMPSLVERR(pslverr[1]),
        .EVENT_IN(evt[1]), .FABINT(fabint[1])
    );

    typedef struct {
        int          d;
        logic [19:0] addr;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          rc0 = 0;
    int          rc1 = 0;
    logic [31:0] mdl_scr    [2][5];
    logic [7:0]  mdl_ctrl   [2];
    logic [7:0]  mdl_status [2];

    // Ready pulses counted mid-cycle
    always @(negedge clk) begin
        if (pready[0] === 1'b1) rc0++;
        if (pready[1] === 1'b1) rc1++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit is_err(input logic [19:0] a);
        return (a[1:0] != 2'b00) || (a > 20'h1C);
    endfunction

    function automatic logic [31:0] mdl_read(input int d, input logic [19:0] a);
        int k;
        if (is_err(a)) return 32'h0;
        case (a)
            20'h00:  return ID;
            20'h04:  return {24'h0, mdl_ctrl[d]};
            20'h08:  return {24'h0, mdl_status[d]};
            default: begin
                k = int'((a - 20'h0C) >> 2);
                return mdl_scr[d][k];
            end
        endcase
    endfunction

    task automatic mdl_write(input int d, input logic [19:0] a, input logic [31:0] wd);
        int k;
        if (is_err(a)) return;
        case (a)
            20'h00:  ;
            20'h04:  mdl_ctrl[d] = wd[7:0];
            20'h08:  mdl_status[d] = mdl_status[d] & ~wd[7:0];
            default: begin
                k = int'((a - 20'h0C) >> 2);
                mdl_scr[d][k] = wd;
            end
        endcase
    endtask

    task automatic mdl_clear();
        for (int d = 0; d < 2; d++) begin
            mdl_ctrl[d]   = 8'h0;
            mdl_status[d] = 8'h0;
            for (int k = 0; k < 5; k++) mdl_scr[d][k] = 32'h0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One APB transfer; evt_rdy is driven during the ready cycle, b2b keeps
    // PSEL high so the next call's setup lands in the DONE cycle.
    task automatic apb_xfer(input int d, input bit wr, input logic [19:0] a,
                            input logic [31:0] wd, input int exp_cyc,
                            input logic [7:0] evt_rdy, input bit b2b);
        exp_t e;
        exp_t got;
        int   n;
        e.d     = d;
        e.addr  = a;
        e.err   = is_err(a);
        e.cyc   = exp_cyc;
        e.rdata = wr ? 32'h0 : mdl_read(d, a);
        sb.push_back(e);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
        tick();
        penable[d] = 1'b1;
        n = 1;
        while (pready[d] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        got = sb.pop_front();
        n_tests++;
        if (pready[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_timeout d=%0d addr=%h: no HMPREADY within %0d cycles", got.d, got.addr, n);
        end else begin
            if (n != got.cyc) begin
                n_fail++;
                $display("FAIL ready_cycle d=%0d addr=%h: got access cycle %0d want %0d", got.d, got.addr, n, got.cyc);
            end
            n_tests++;
            if (prdata[d] !== got.rdata) begin
                n_fail++;
                $display("FAIL rdata d=%0d addr=%h: got %h want %h", got.d, got.addr, prdata[d], got.rdata);
            end
            n_tests++;
            if (pslverr[d] !== got.err) begin
                n_fail++;
                $display("FAIL slverr d=%0d addr=%h: got %b want %b", got.d, got.addr, pslverr[d], got.err);
            end
            if (wr) mdl_write(d, a, wd);
            mdl_status[d] = mdl_status[d] | evt_rdy;
            evt[d] = evt_rdy;
        end
        tick();
        evt[d] = 8'h0;
        n_tests++;
        if (pready[d] !== 1'b0 || prdata[d] !== 32'h0) begin
            n_fail++;
            $display("FAIL ready_one_cycle d=%0d addr=%h: got ready=%b rdata=%h want 0/0", d, a, pready[d], prdata[d]);
        end
        if (!b2b) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            tick();
        end
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        n_tests++;
        if (pready[d] !== 1'b0) begin n_fail++; $display("FAIL %s_ready d=%0d: got %b want 0", tag, d, pready[d]); end
        n_tests++;
        if (pslverr[d] !== 1'b0) begin n_fail++; $display("FAIL %s_slverr d=%0d: got %b want 0", tag, d, pslverr[d]); end
        n_tests++;
        if (prdata[d] !== 32'h0) begin n_fail++; $display("FAIL %s_rdata d=%0d: got %h want 0", tag, d, prdata[d]); end
        n_tests++;
        if (fabint[d] !== 1'b0) begin n_fail++; $display("FAIL %s_fabint d=%0d: got %b want 0", tag, d, fabint[d]); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        mdl_clear();
        check_idle_outputs(0, "reset");
        check_idle_outputs(1, "reset");
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ws1_rw();
        apb_xfer(1, 1'b1, 20'h0C, 32'hDEAD_BEEF, 2, 8'h0, 1'b0);
        apb_xfer(1, 1'b0, 20'h0C, 32'h0,         2, 8'h0, 1'b0);
    endtask

    task automatic test_ws0_id();
        apb_xfer(0, 1'b0, 20'h00, 32'h0, 1, 8'h0, 1'b0);
        apb_xfer(0, 1'b1, 20'h00, 32'h0, 1, 8'h0, 1'b0);
        apb_xfer(0, 1'b0, 20'h00, 32'h0, 1, 8'h0, 1'b0);
        apb_xfer(0, 1'b1, 20'h1C, 32'h0BAD_F00D, 1, 8'h0, 1'b0);
        apb_xfer(0, 1'b0, 20'h1C, 32'h0, 1, 8'h0, 1'b0);
    endtask

    task automatic test_errors();
        for (int k = 0; k < 5; k++)
            apb_xfer(1, 1'b1, 20'(20'h0C + 4 * k), 32'h1111_1111 * (k + 1), 2, 8'h0, 1'b0);
        apb_xfer(1, 1'b0, 20'h20, 32'h0,         2, 8'h0, 1'b0);
        apb_xfer(1, 1'b1, 20'h06, 32'hFFFF_FFFF, 2, 8'h0, 1'b0);
        apb_xfer(1, 1'b0, 20'h0E, 32'h0,         2, 8'h0, 1'b0);
        apb_xfer(1, 1'b1, 20'h24, 32'hFFFF_FFFF, 2, 8'h0, 1'b0);
        for (int k = 0; k < 5; k++)
            apb_xfer(1, 1'b0, 20'(20'h0C + 4 * k), 32'h0, 2, 8'h0, 1'b0);
    endtask

    task automatic test_irq();
        apb_xfer(1, 1'b1, 20'h04, 32'hFFFF_FFA5, 2, 8'h0, 1'b0);
        apb_xfer(1, 1'b0, 20'h04, 32'h0,         2, 8'h0, 1'b0);
        apb_xfer(1, 1'b1, 20'h04, 32'h0000_0001, 2, 8'h0, 1'b0);
        evt[1] = 8'h01;
        tick();
        evt[1] = 8'h00;
        mdl_status[1] = mdl_status[1] | 8'h01;
        n_tests++;
        if (fabint[1] !== 1'b0) begin n_fail++; $display("FAIL fabint_early: got %b want 0", fabint[1]); end
        tick();
        n_tests++;
        if (fabint[1] !== 1'b1) begin n_fail++; $display("FAIL fabint_rise: got %b want 1", fabint[1]); end
        // W1C of bit 0 coinciding with a new event on bit 0
        apb_xfer(1, 1'b1, 20'h08, 32'h0000_0001, 2, 8'h01, 1'b0);
        n_tests++;
        if (fabint[1] !== 1'b1) begin n_fail++; $display("FAIL fabint_set_wins: got %b want 1", fabint[1]); end
        apb_xfer(1, 1'b0, 20'h08, 32'h0, 2, 8'h0, 1'b0);
        n_tests++;
        if (fabint[1] !== 1'b1) begin n_fail++; $display("FAIL fabint_hold: got %b want 1", fabint[1]); end
        // Plain clear drops the interrupt
        apb_xfer(1, 1'b1, 20'h08, 32'h0000_0001, 2, 8'h0, 1'b0);
        n_tests++;
        if (fabint[1] !== 1'b0) begin n_fail++; $display("FAIL fabint_clear: got %b want 0", fabint[1]); end
        apb_xfer(1, 1'b0, 20'h08, 32'h0, 2, 8'h0, 1'b0);
    endtask

    task automatic test_abort_reset();
        int rcb;
        apb_xfer(1, 1'b1, 20'h10, 32'h1234_5678, 2, 8'h0, 1'b0);
        rcb = rc1;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 20'h10; pwdata[1] = 32'hBAD0_BAD0;
        tick();
        psel[1] = 1'b0; penable[1] = 1'b0;
        repeat (4) tick();
        n_tests++;
        if (rc1 != rcb) begin n_fail++; $display("FAIL abort_ready: got %0d pulses want 0", rc1 - rcb); end
        apb_xfer(1, 1'b0, 20'h10, 32'h0, 2, 8'h0, 1'b0);

        // Raise the interrupt so the reset check sees it fall
        evt[1] = 8'h01;
        tick();
        evt[1] = 8'h00;
        tick();
        tick();
        n_tests++;
        if (fabint[1] !== 1'b1) begin n_fail++; $display("FAIL fabint_pre_reset: got %b want 1", fabint[1]); end
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 20'h14; pwdata[1] = 32'h0000_CAFE;
        tick();
        penable[1] = 1'b1;
        rst = 1'b1;
        tick();
        check_idle_outputs(1, "midreset");
        rst = 1'b0;
        mdl_clear();
        rcb = rc1;
        repeat (3) tick();
        n_tests++;
        if (rc1 != rcb) begin n_fail++; $display("FAIL post_reset_ready: got %0d pulses want 0", rc1 - rcb); end
        psel[1] = 1'b0; penable[1] = 1'b0; pwrite[1] = 1'b0;
        tick();
        apb_xfer(1, 1'b0, 20'h14, 32'h0, 2, 8'h0, 1'b0);
        apb_xfer(1, 1'b0, 20'h04, 32'h0, 2, 8'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int rcb;
        rcb = rc1;
        apb_xfer(1, 1'b1, 20'h18, 32'hA5A5_0001, 2, 8'h0, 1'b1);
        apb_xfer(1, 1'b1, 20'h1C, 32'h5A5A_0002, 2, 8'h0, 1'b0);
        n_tests++;
        if (rc1 - rcb != 2) begin n_fail++; $display("FAIL b2b_pulses d=1: got %0d want 2", rc1 - rcb); end
        apb_xfer(1, 1'b0, 20'h18, 32'h0, 2, 8'h0, 1'b1);
        apb_xfer(1, 1'b0, 20'h1C, 32'h0, 2, 8'h0, 1'b0);

        rcb = rc0;
        apb_xfer(0, 1'b1, 20'h0C, 32'hC0DE_0003, 1, 8'h0, 1'b1);
        apb_xfer(0, 1'b1, 20'h10, 32'hC0DE_0004, 1, 8'h0, 1'b1);
        apb_xfer(0, 1'b0, 20'h0C, 32'h0,         1, 8'h0, 1'b1);
        apb_xfer(0, 1'b0, 20'h10, 32'h0,         1, 8'h0, 1'b0);
        n_tests++;
        if (rc0 - rcb != 4) begin n_fail++; $display("FAIL b2b_pulses d=0: got %0d want 4", rc0 - rcb); end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = 20'h0; pwdata[d] = 32'h0; evt[d] = 8'h0;
        end
        mdl_clear();
        tick();
        test_reset();
        test_ws1_rw();
        test_ws0_id();
        test_errors();
        test_irq();
        test_abort_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
